// File: rtl/csi2_frame_gate.sv
// Whole-frame gate for CSI-2 pixel AXI4-Stream: 1-cycle register slice, SOF-aligned
// enable, per-frame width/height measurement and sticky framing error flags.
module csi2_frame_gate #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                    px_clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    clear_err_i,
    input  logic [DATA_WIDTH-1:0]   s_tdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb_i,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep_i,
    input  logic                    s_tuser_i,
    input  logic [ID_WIDTH-1:0]     s_tid_i,
    input  logic [DEST_WIDTH-1:0]   s_tdest_i,
    input  logic                    s_tlast_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    output logic [DATA_WIDTH-1:0]   m_tdata_o,
    output logic [DATA_WIDTH/8-1:0] m_tstrb_o,
    output logic [DATA_WIDTH/8-1:0] m_tkeep_o,
    output logic                    m_tuser_o,
    output logic [ID_WIDTH-1:0]     m_tid_o,
    output logic [DEST_WIDTH-1:0]   m_tdest_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic [CNT_WIDTH-1:0]    frame_width_o,
    output logic [CNT_WIDTH-1:0]    frame_height_o,
    output logic                    res_valid_o,
    output logic [15:0]             frame_cnt_o,
    output logic                    line_len_err_o,
    output logic                    sof_mid_line_err_o
);
    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic [0:0] {WAIT_SOF, PASS} state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                  state_q, state_d;
    logic                    acc, fwd, fcnt_inc;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic [KW-1:0]           m_tstrb_q, m_tkeep_q;
    logic                    m_tuser_q, m_tlast_q, m_tvalid_q;
    logic [ID_WIDTH-1:0]     m_tid_q;
    logic [DEST_WIDTH-1:0]   m_tdest_q;
    logic [15:0]             frame_cnt_q;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]    ref_width_q, ref_width_d, width_q, width_d, height_q, height_d;
    logic [CNT_WIDTH-1:0]    beat_base, line_base, line_len;
    logic                    res_valid_q, res_valid_d, sof_seen_q, sof_seen_d;
    logic                    len_err_q, sof_err_q, len_err_set, sof_err_set;

    assign s_tready_o = !m_tvalid_q | m_tready_i;
    assign acc        = s_tvalid_i & s_tready_o;

    // Gating decisions are only taken on SOF beats, so frames are never cut short.
    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        fcnt_inc = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (acc && s_tuser_i && enable_i) begin
                    fwd      = 1'b1;
                    fcnt_inc = 1'b1;
                    state_d  = PASS;
                end
            end
            PASS: begin
                if (acc && s_tuser_i) begin
                    if (enable_i) begin
                        fwd      = 1'b1;
                        fcnt_inc = 1'b1;
                    end else begin
                        state_d = WAIT_SOF;
                    end
                end else begin
                    fwd = acc;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // An SOF beat restarts the frame and counts as beat 1 of its first line.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        line_cnt_d  = line_cnt_q;
        ref_width_d = ref_width_q;
        width_d     = width_q;
        height_d    = height_q;
        res_valid_d = 1'b0;
        sof_seen_d  = sof_seen_q;
        len_err_set = 1'b0;
        sof_err_set = 1'b0;
        beat_base   = s_tuser_i ? '0 : beat_cnt_q;
        line_base   = s_tuser_i ? '0 : line_cnt_q;
        line_len    = sat_inc(beat_base);
        if (acc) begin
            if (s_tuser_i) begin
                sof_seen_d  = 1'b1;
                sof_err_set = (beat_cnt_q != '0);
                if (line_cnt_q != '0) begin
                    width_d     = ref_width_q;
                    height_d    = line_cnt_q;
                    res_valid_d = 1'b1;
                end
                line_cnt_d  = '0;
                ref_width_d = '0;
            end
            if (s_tlast_i) begin
                beat_cnt_d = '0;
                // Lines seen before the first SOF after reset belong to no measurable frame.
                if (sof_seen_d) begin
                    line_cnt_d = sat_inc(line_base);
                    if (line_base == '0) begin
                        ref_width_d = line_len;
                    end else if (line_len != ref_width_q) begin
                        len_err_set = 1'b1;
                    end
                end
            end else begin
                beat_cnt_d = line_len;
            end
        end
    end

    always_ff @(posedge px_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_SOF;
            m_tdata_q   <= '0;
            m_tstrb_q   <= '0;
            m_tkeep_q   <= '0;
            m_tuser_q   <= 1'b0;
            m_tid_q     <= '0;
            m_tdest_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            frame_cnt_q <= '0;
            beat_cnt_q  <= '0;
            line_cnt_q  <= '0;
            ref_width_q <= '0;
            width_q     <= '0;
            height_q    <= '0;
            res_valid_q <= 1'b0;
            sof_seen_q  <= 1'b0;
            len_err_q   <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fwd) begin
                m_tdata_q  <= s_tdata_i;
                m_tstrb_q  <= s_tstrb_i;
                m_tkeep_q  <= s_tkeep_i;
                m_tuser_q  <= s_tuser_i;
                m_tid_q    <= s_tid_i;
                m_tdest_q  <= s_tdest_i;
                m_tlast_q  <= s_tlast_i;
                m_tvalid_q <= 1'b1;
            end else if (m_tready_i) begin
                m_tvalid_q <= 1'b0;
            end
            if (fcnt_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            beat_cnt_q  <= beat_cnt_d;
            line_cnt_q  <= line_cnt_d;
            ref_width_q <= ref_width_d;
            width_q     <= width_d;
            height_q    <= height_d;
            res_valid_q <= res_valid_d;
            sof_seen_q  <= sof_seen_d;
            len_err_q   <= len_err_set | (len_err_q & ~clear_err_i);
            sof_err_q   <= sof_err_set | (sof_err_q & ~clear_err_i);
        end
    end

    assign m_tdata_o          = m_tdata_q;
    assign m_tstrb_o          = m_tstrb_q;
    assign m_tkeep_o          = m_tkeep_q;
    assign m_tuser_o          = m_tuser_q;
    assign m_tid_o            = m_tid_q;
    assign m_tdest_o          = m_tdest_q;
    assign m_tlast_o          = m_tlast_q;
    assign m_tvalid_o         = m_tvalid_q;
    assign frame_width_o      = width_q;
    assign frame_height_o     = height_q;
    assign res_valid_o        = res_valid_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign line_len_err_o     = len_err_q;
    assign sof_mid_line_err_o = sof_err_q;
endmodule

// File: tb/tb_csi2_frame_gate.sv
// Randomized bench for csi2_frame_gate against a frame-level reference model.
module tb_csi2_frame_gate;
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic [1:0]  keep;
        logic        user;
        logic        id;
        logic        dest;
        logic        last;
    } beat_t;

    logic        px_clk_i = 1'b0;
    logic        rst_n_i, enable_i, clear_err_i;
    logic [15:0] s_tdata_i;
    logic [1:0]  s_tstrb_i, s_tkeep_i;
    logic        s_tuser_i, s_tlast_i, s_tvalid_i, s_tready_o;
    logic [0:0]  s_tid_i, s_tdest_i;
    logic [15:0] m_tdata_o;
    logic [1:0]  m_tstrb_o, m_tkeep_o;
    logic        m_tuser_o, m_tlast_o, m_tvalid_o, m_tready_i;
    logic [0:0]  m_tid_o, m_tdest_o;
    logic [12:0] frame_width_o, frame_height_o;
    logic        res_valid_o, line_len_err_o, sof_mid_line_err_o;
    logic [15:0] frame_cnt_o;

    csi2_frame_gate dut (
        .px_clk_i(px_clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .clear_err_i(clear_err_i),
        .s_tdata_i(s_tdata_i), .s_tstrb_i(s_tstrb_i), .s_tkeep_i(s_tkeep_i), .s_tuser_i(s_tuser_i),
        .s_tid_i(s_tid_i), .s_tdest_i(s_tdest_i), .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .m_tdata_o(m_tdata_o), .m_tstrb_o(m_tstrb_o), .m_tkeep_o(m_tkeep_o), .m_tuser_o(m_tuser_o),
        .m_tid_o(m_tid_o), .m_tdest_o(m_tdest_o), .m_tlast_o(m_tlast_o), .m_tvalid_o(m_tvalid_o),
        .m_tready_i(m_tready_i),
        .frame_width_o(frame_width_o), .frame_height_o(frame_height_o), .res_valid_o(res_valid_o),
        .frame_cnt_o(frame_cnt_o), .line_len_err_o(line_len_err_o),
        .sof_mid_line_err_o(sof_mid_line_err_o)
    );

    always #5 px_clk_i = ~px_clk_i;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    bit rand_rdy = 0, gaps = 0;

    // Reference model: gate state, frame count, and the list of line lengths of the current frame.
    bit    m_pass, m_in_frame, m_len_err, m_sof_err;
    int    m_fcnt, m_beats;
    int    m_lines[$];
    beat_t exp_q[$];
    int    exp_cyc_q[$], exp_res_w[$], exp_res_h[$];

    beat_t obs_q[$];
    int    obs_cyc_q[$], obs_res_w[$], obs_res_h[$];
    int    stab_viol = 0;
    bit    hold = 0;
    beat_t held, cur;
    int    app_cyc = 0;

    always @(posedge px_clk_i) cyc <= cyc + 1;

    initial begin
        m_tready_i = 1'b1;
        forever begin
            @(posedge px_clk_i);
            #1;
            m_tready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge px_clk_i) begin
        if (!rst_n_i) begin
            hold = 0;
        end else begin
            if (m_tvalid_o) begin
                cur = {m_tdata_o, m_tstrb_o, m_tkeep_o, m_tuser_o, m_tid_o, m_tdest_o, m_tlast_o};
                if (hold) begin
                    if (cur !== held) stab_viol++;
                end else begin
                    app_cyc = cyc;
                end
                if (m_tready_i) begin
                    obs_q.push_back(cur);
                    obs_cyc_q.push_back(app_cyc);
                end
                hold = !m_tready_i;
                held = cur;
            end else begin
                if (hold) stab_viol++;
                hold = 0;
            end
            if (res_valid_o) begin
                obs_res_w.push_back(int'(frame_width_o));
                obs_res_h.push_back(int'(frame_height_o));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pass = 0; m_in_frame = 0; m_len_err = 0; m_sof_err = 0;
        m_fcnt = 0; m_beats = 0;
        m_lines.delete();
    endtask

    task automatic flush_q();
        exp_q.delete(); exp_cyc_q.delete(); exp_res_w.delete(); exp_res_h.delete();
        obs_q.delete(); obs_cyc_q.delete(); obs_res_w.delete(); obs_res_h.delete();
        stab_viol = 0;
    endtask

    task automatic model_accept(input beat_t b, input bit en);
        bit fwd;
        if (b.user) begin
            if (m_in_frame && m_lines.size() > 0) begin
                exp_res_w.push_back(m_lines[0]);
                exp_res_h.push_back(m_lines.size());
            end
            if (m_beats != 0) m_sof_err = 1;
            m_lines.delete();
            m_in_frame = 1;
            m_beats = 0;
            fwd = en;
            m_pass = en;
            if (en) m_fcnt = (m_fcnt + 1) % 65536;
        end else begin
            fwd = m_pass;
        end
        m_beats++;
        if (b.last) begin
            if (m_in_frame) begin
                m_lines.push_back(m_beats);
                if (m_lines.size() > 1 && m_beats != m_lines[0]) m_len_err = 1;
            end
            m_beats = 0;
        end
        if (fwd) begin
            exp_q.push_back(b);
            exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic send_beat(input beat_t b);
        int  n = 0;
        bit  done = 0;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            s_tvalid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge px_clk_i);
            #1;
        end
        {s_tdata_i, s_tstrb_i, s_tkeep_i, s_tuser_i, s_tid_i, s_tdest_i, s_tlast_i} = b;
        s_tvalid_i = 1'b1;
        while (!done) begin
            @(negedge px_clk_i);
            if (s_tready_o) begin
                model_accept(b, enable_i);
                done = 1;
            end
            @(posedge px_clk_i);
            #1;
            n++;
            if (!done && n > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL handshake_timeout: s_tready_o stayed %0d, required 1", s_tready_o);
                done = 1;
            end
        end
        s_tvalid_i = 1'b0;
    endtask

    task automatic send_line(input int n, input bit sof, input bit last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 16'($urandom);
            b.strb = 2'($urandom);
            b.keep = 2'($urandom);
            b.id   = 1'($urandom);
            b.dest = 1'($urandom);
            b.user = sof && (i == 0);
            b.last = last && (i == n - 1);
            send_beat(b);
        end
    endtask

    task automatic send_frame(input int lines, input int beats);
        for (int l = 0; l < lines; l++) send_line(beats, l == 0, 1'b1);
    endtask

    task automatic settle();
        int n = 0;
        s_tvalid_i = 1'b0;
        while (obs_q.size() < exp_q.size() && n < 500) begin
            @(posedge px_clk_i);
            n++;
        end
        repeat (3) @(posedge px_clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; enable_i = 1'b0; clear_err_i = 1'b0;
        s_tdata_i = '0; s_tstrb_i = '0; s_tkeep_i = '0; s_tuser_i = 1'b0;
        s_tid_i = '0; s_tdest_i = '0; s_tlast_i = 1'b0; s_tvalid_i = 1'b0;
        model_reset();
        repeat (3) @(posedge px_clk_i);
        @(negedge px_clk_i);
        n_cmp++;
        if (m_tvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_tvalid: got %0d required 0", m_tvalid_o);
        end
        n_cmp++;
        if ({m_tdata_o, m_tstrb_o, m_tkeep_o, m_tuser_o, m_tid_o, m_tdest_o, m_tlast_o} !== '0) begin
            n_fail++; $display("FAIL reset_m_fields: got data %h user %0d last %0d required all 0",
                               m_tdata_o, m_tuser_o, m_tlast_o);
        end
        n_cmp++;
        if (frame_cnt_o !== 16'd0 || frame_width_o !== 13'd0 || frame_height_o !== 13'd0) begin
            n_fail++; $display("FAIL reset_counts: got cnt %0d w %0d h %0d required 0 0 0",
                               frame_cnt_o, frame_width_o, frame_height_o);
        end
        n_cmp++;
        if ({res_valid_o, line_len_err_o, sof_mid_line_err_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000",
                               {res_valid_o, line_len_err_o, sof_mid_line_err_o});
        end
        n_cmp++;
        if (s_tready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_s_tready: got %0d required 1", s_tready_o);
        end
        rst_n_i = 1'b1;
        @(posedge px_clk_i);
        #1;
    endtask

    task automatic test_basic();
        flush_q();
        enable_i = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(4, 8);
        settle();
        n_cmp++;
        if (obs_q.size() !== 96 || exp_q.size() !== 96) begin
            n_fail++; $display("FAIL basic_count: got %0d beats (model %0d) required 96", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
                n_fail++; $display("FAIL basic_beat[%0d]: got %h @%0d required %h @%0d",
                                   i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_cmp++;
        if (frame_cnt_o !== 16'd3) begin
            n_fail++; $display("FAIL basic_frame_cnt: got %0d required 3", frame_cnt_o);
        end
        n_cmp++;
        if (obs_res_w.size() !== 2) begin
            n_fail++; $display("FAIL basic_res_pulses: got %0d required 2", obs_res_w.size());
        end
        for (int i = 0; i < obs_res_w.size(); i++) begin
            n_cmp++;
            if (obs_res_w[i] !== 8 || obs_res_h[i] !== 4) begin
                n_fail++; $display("FAIL basic_res[%0d]: got %0dx%0d required 8x4", i, obs_res_w[i], obs_res_h[i]);
            end
        end
    endtask

    task automatic test_enable_mid();
        int fc0;
        flush_q();
        fc0 = m_fcnt;
        enable_i = 1'b0;
        send_line(8, 1'b1, 1'b1);
        send_line(8, 1'b0, 1'b1);
        enable_i = 1'b1;
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_frame(4, 8);
        send_frame(4, 8);
        settle();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL enmid_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
                n_fail++; $display("FAIL enmid_beat[%0d]: got %h @%0d required %h @%0d",
                                   i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() == 0 || obs_q[0].user !== 1'b1) begin
            n_fail++; $display("FAIL enmid_first_user: got %0d beats, first user not 1, required 1", obs_q.size());
        end
        n_cmp++;
        if (frame_cnt_o !== 16'(fc0 + 2)) begin
            n_fail++; $display("FAIL enmid_frame_cnt: got %0d required %0d", frame_cnt_o, fc0 + 2);
        end
    endtask

    task automatic test_disable_mid();
        int fc0;
        flush_q();
        fc0 = m_fcnt;
        enable_i = 1'b1;
        send_line(8, 1'b1, 1'b1);
        send_line(3, 1'b0, 1'b0);
        enable_i = 1'b0;
        send_line(5, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_frame(4, 8);
        settle();
        n_cmp++;
        if (obs_q.size() !== 32 || exp_q.size() !== 32) begin
            n_fail++; $display("FAIL dismid_count: got %0d beats (model %0d) required 32", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL dismid_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_cnt_o !== 16'(fc0 + 1)) begin
            n_fail++; $display("FAIL dismid_frame_cnt: got %0d required %0d", frame_cnt_o, fc0 + 1);
        end
    endtask

    task automatic test_backpressure();
        flush_q();
        enable_i = 1'b1;
        rand_rdy = 1; gaps = 1;
        for (int f = 0; f < 4; f++) send_frame($urandom_range(2, 4), $urandom_range(3, 8));
        send_line(4, 1'b1, 1'b1);
        settle();
        rand_rdy = 0; gaps = 0;
        settle();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
                n_fail++; $display("FAIL bp_beat[%0d]: got %h @%0d required %h @%0d",
                                   i, obs_q[i], obs_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_cmp++;
        if (stab_viol !== 0) begin
            n_fail++; $display("FAIL bp_stability: got %0d held-beat changes required 0", stab_viol);
        end
        n_cmp++;
        if (obs_res_w.size() !== exp_res_w.size()) begin
            n_fail++; $display("FAIL bp_res_count: got %0d required %0d", obs_res_w.size(), exp_res_w.size());
        end
        for (int i = 0; i < exp_res_w.size() && i < obs_res_w.size(); i++) begin
            n_cmp++;
            if (obs_res_w[i] !== exp_res_w[i] || obs_res_h[i] !== exp_res_h[i]) begin
                n_fail++; $display("FAIL bp_res[%0d]: got %0dx%0d required %0dx%0d",
                                   i, obs_res_w[i], obs_res_h[i], exp_res_w[i], exp_res_h[i]);
            end
        end
        n_cmp++;
        if (frame_cnt_o !== 16'(m_fcnt)) begin
            n_fail++; $display("FAIL bp_frame_cnt: got %0d required %0d", frame_cnt_o, m_fcnt);
        end
    endtask

    task automatic test_line_err();
        flush_q();
        enable_i = 1'b1;
        n_cmp++;
        if (line_len_err_o !== 1'b0) begin
            n_fail++; $display("FAIL lenerr_pre: got %0d required 0", line_len_err_o);
        end
        send_line(8, 1'b1, 1'b1);
        send_line(7, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        settle();
        n_cmp++;
        if (line_len_err_o !== m_len_err || m_len_err !== 1'b1) begin
            n_fail++; $display("FAIL lenerr_set: got %0d required 1", line_len_err_o);
        end
        send_frame(4, 8);
        settle();
        n_cmp++;
        if (line_len_err_o !== 1'b1) begin
            n_fail++; $display("FAIL lenerr_sticky: got %0d required 1", line_len_err_o);
        end
        clear_err_i = 1'b1;
        @(posedge px_clk_i); #1;
        clear_err_i = 1'b0;
        m_len_err = 0; m_sof_err = 0;
        @(negedge px_clk_i);
        n_cmp++;
        if (line_len_err_o !== 1'b0 || sof_mid_line_err_o !== 1'b0) begin
            n_fail++; $display("FAIL lenerr_clear: got len %0d sof %0d required 0 0", line_len_err_o, sof_mid_line_err_o);
        end
        @(posedge px_clk_i); #1;
    endtask

    task automatic test_sof_mid();
        flush_q();
        enable_i = 1'b1;
        send_line(8, 1'b1, 1'b1);
        send_line(2, 1'b0, 1'b0);
        send_frame(4, 8);
        send_line(8, 1'b1, 1'b1);
        settle();
        n_cmp++;
        if (sof_mid_line_err_o !== m_sof_err || m_sof_err !== 1'b1) begin
            n_fail++; $display("FAIL sofmid_flag: got %0d required 1", sof_mid_line_err_o);
        end
        n_cmp++;
        if (line_len_err_o !== m_len_err) begin
            n_fail++; $display("FAIL sofmid_lenerr: got %0d required %0d", line_len_err_o, m_len_err);
        end
        n_cmp++;
        if (obs_res_w.size() !== exp_res_w.size()) begin
            n_fail++; $display("FAIL sofmid_res_count: got %0d required %0d", obs_res_w.size(), exp_res_w.size());
        end
        for (int i = 0; i < exp_res_w.size() && i < obs_res_w.size(); i++) begin
            n_cmp++;
            if (obs_res_w[i] !== exp_res_w[i] || obs_res_h[i] !== exp_res_h[i]) begin
                n_fail++; $display("FAIL sofmid_res[%0d]: got %0dx%0d required %0dx%0d",
                                   i, obs_res_w[i], obs_res_h[i], exp_res_w[i], exp_res_h[i]);
            end
        end
        n_cmp++;
        if (frame_width_o !== 13'd8 || frame_height_o !== 13'd4) begin
            n_fail++; $display("FAIL sofmid_last_res: got %0dx%0d required 8x4", frame_width_o, frame_height_o);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL sofmid_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        flush_q();
        enable_i = 1'b1;
        send_line(8, 1'b1, 1'b1);
        send_line(4, 1'b0, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        n_cmp++;
        if (m_tvalid_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_async: got tvalid %0d cnt %0d required 0 0", m_tvalid_o, frame_cnt_o);
        end
        model_reset();
        flush_q();
        @(negedge px_clk_i);
        rst_n_i = 1'b1;
        @(posedge px_clk_i); #1;
        send_line(4, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_frame(2, 8);
        settle();
        n_cmp++;
        if (obs_q.size() !== 16 || exp_q.size() !== 16) begin
            n_fail++; $display("FAIL rstmid_count: got %0d beats (model %0d) required 16", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_cnt_o !== 16'd1 || obs_res_w.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_after: got cnt %0d res pulses %0d required 1 0", frame_cnt_o, obs_res_w.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_mid();
        test_disable_mid();
        test_backpressure();
        test_line_err();
        test_sof_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
